// File: rtl/split_every3_pkg.sv
// rtl/split_every3_pkg.sv - shared defaults and sample/group types for split_every3
package split_every3_pkg;

    localparam int DEF_DW = 10;
    localparam int DEF_N  = 3;

    typedef logic [DEF_DW-1:0]   sample_t;
    typedef sample_t [DEF_N-1:0] group_t;

endpackage

// File: rtl/split_every3_group_buf2.sv
// rtl/split_every3_group_buf2.sv - two-entry group FIFO feeding the serialiser
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push, wdata   write one packed group (caller guarantees !full)
//   pop           retire the head group (caller guarantees !empty)
//   rdata         head group, slot[rd_ptr]
//   full, empty   occupancy flags derived from cnt
module group_buf2 #(
    parameter int DW = 10,
    parameter int N  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [N*DW-1:0] wdata,
    input  logic            pop,
    output logic [N*DW-1:0] rdata,
    output logic            full,
    output logic            empty
);

    logic [N*DW-1:0] slot [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                slot[k] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= wdata;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = slot[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/split_every3.sv
// rtl/split_every3.sv - replays packed N-sample groups as a serial sample stream
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   i_dval, i_rdy, i     group input handshake; element k at i[k*DW +: DW]
//   o_dval, o_rdy, o     sample output handshake, element 0 of each group first
//   o_last               high while o carries element N-1
//   o_ovf                sticky: a group was offered while i_rdy was low
module split_every3
    import split_every3_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_dval,
    output logic            i_rdy,
    input  logic [N*DW-1:0] i,
    output logic            o_dval,
    input  logic            o_rdy,
    output logic [DW-1:0]   o,
    output logic            o_last,
    output logic            o_ovf
);

    localparam int IDX_W = $clog2(N);

    logic                 rdy_en;
    logic [IDX_W-1:0]     idx;
    logic [N*DW-1:0]      head;
    logic [N-1:0][DW-1:0] head_el;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 beat;
    logic                 at_last;

    group_buf2 #(
        .DW (DW),
        .N  (N)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (i),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Holds i_rdy low through reset and the edge that releases it, so
    // readiness is a pure function of registered state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign i_rdy   = rdy_en && !full;
    assign push    = i_dval && i_rdy;
    assign o_dval  = !empty;
    assign at_last = (idx == IDX_W'(N - 1));
    assign beat    = o_dval && o_rdy;
    assign pop     = beat && at_last;
    assign head_el = head;
    assign o       = head_el[idx];
    assign o_last  = o_dval && at_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx <= '0;
        end else if (beat) begin
            idx <= at_last ? '0 : idx + IDX_W'(1);
        end
    end

    // Only a full buffer counts as overflow; the reset-recovery cycle,
    // where i_rdy is also low, does not.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_ovf <= 1'b0;
        end else if (i_dval && rdy_en && full) begin
            o_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_split_every3.sv
// tb/tb_split_every3.sv - directed self-checking bench for split_every3
module tb_split_every3;

    localparam int DW = 10;
    localparam int N  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_dval;
    logic            i_rdy;
    logic [N*DW-1:0] i;
    logic            o_dval;
    logic            o_rdy;
    logic [DW-1:0]   o;
    logic            o_last;
    logic            o_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    split_every3 #(.DW(DW), .N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_dval (i_dval),
        .i_rdy  (i_rdy),
        .i      (i),
        .o_dval (o_dval),
        .o_rdy  (o_rdy),
        .o      (o),
        .o_last (o_last),
        .o_ovf  (o_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] grp(input int e0, input int e1, input int e2);
        return {DW'(e2), DW'(e1), DW'(e0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int val, input logic last);
        chk({tag, "_dval"}, 32'(o_dval), 32'd1);
        chk({tag, "_o"}, 32'(o), 32'(val));
        chk({tag, "_last"}, 32'(o_last), 32'(last));
    endtask

    logic [N*DW-1:0] groups [3];
    int              gi;
    int              k;
    logic            acc;

    initial begin
        rst    = 1'b0;
        i_dval = 1'b1;
        i      = grp(5, 6, 7);
        o_rdy  = 1'b1;

        // Reset held with a group offered.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst_i_rdy", 32'(i_rdy), 32'd0);
            chk("rst_o_dval", 32'(o_dval), 32'd0);
            chk("rst_o_ovf", 32'(o_ovf), 32'd0);
        end
        chk("rst_o", 32'(o), 32'd0);
        chk("rst_o_last", 32'(o_last), 32'd0);
        i_dval = 1'b0;
        rst    = 1'b1;
        tick();
        chk("post_rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("post_rst_o_dval", 32'(o_dval), 32'd0);

        // Single group {3,2,1}, element 0 = 1.
        i      = grp(1, 2, 3);
        i_dval = 1'b1;
        tick();
        i_dval = 1'b0;
        chk_beat("single0", 1, 1'b0);
        tick();
        chk_beat("single1", 2, 1'b0);
        tick();
        chk_beat("single2", 3, 1'b1);
        tick();
        chk("single_idle", 32'(o_dval), 32'd0);

        // Back-to-back groups with o_rdy held high: 1..9 without gaps.
        groups[0] = grp(1, 2, 3);
        groups[1] = grp(4, 5, 6);
        groups[2] = grp(7, 8, 9);
        gi = 0;
        k  = 0;
        for (int c = 0; c < 30 && k < 9; c++) begin
            i_dval = (gi < 3);
            i      = groups[gi < 3 ? gi : 2];
            acc    = i_dval && i_rdy;
            tick();
            if (acc) gi++;
            chk_beat("b2b", k + 1, (k % 3) == 2);
            k++;
        end
        i_dval = 1'b0;
        chk("b2b_count", 32'(k), 32'd9);
        tick();
        chk("b2b_idle", 32'(o_dval), 32'd0);

        // Backpressure: two groups buffered, output stalled.
        o_rdy  = 1'b0;
        i_dval = 1'b1;
        i      = grp(10, 11, 12);
        tick();
        i      = grp(13, 14, 15);
        tick();
        i_dval = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk_beat("stall", 10, 1'b0);
            chk("stall_i_rdy", 32'(i_rdy), 32'd0);
            tick();
        end

        // Overflow while full: group dropped, flag sticks.
        i_dval = 1'b1;
        i      = grp(9, 9, 9);
        tick();
        i_dval = 1'b0;
        chk("ovf_set", 32'(o_ovf), 32'd1);
        chk_beat("ovf_hold", 10, 1'b0);

        o_rdy = 1'b1;
        tick();
        chk_beat("rel1", 11, 1'b0);
        chk("rel1_i_rdy", 32'(i_rdy), 32'd0);
        tick();
        chk_beat("rel2", 12, 1'b1);
        chk("rel2_i_rdy", 32'(i_rdy), 32'd0);
        tick();
        chk_beat("rel3", 13, 1'b0);
        chk("after_pop_i_rdy", 32'(i_rdy), 32'd1);
        tick();
        chk_beat("rel4", 14, 1'b0);
        tick();
        chk_beat("rel5", 15, 1'b1);
        tick();
        chk("rel_idle", 32'(o_dval), 32'd0);
        chk("ovf_sticky", 32'(o_ovf), 32'd1);

        // Reset after two beats of a group.
        i_dval = 1'b1;
        i      = grp(20, 21, 22);
        tick();
        i_dval = 1'b0;
        chk_beat("mid0", 20, 1'b0);
        tick();
        chk_beat("mid1", 21, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_rst_o_dval", 32'(o_dval), 32'd0);
        chk("mid_rst_ovf", 32'(o_ovf), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_post_o_dval", 32'(o_dval), 32'd0);
        chk("mid_post_i_rdy", 32'(i_rdy), 32'd1);
        i_dval = 1'b1;
        i      = grp(30, 31, 32);
        tick();
        i_dval = 1'b0;
        chk_beat("after0", 30, 1'b0);
        tick();
        chk_beat("after1", 31, 1'b0);
        tick();
        chk_beat("after2", 32, 1'b1);
        tick();
        chk("after_idle", 32'(o_dval), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
